npc_seq_ctrl: RTL and testbench

Multi-cycle sequencer for the NPC core. It steps each instruction through fetch, decode, execute, memory and writeback phases around the combinational control unit. It drives valid/ready handshakes to the instruction-fetch port, the multi-cycle MUL/DIV unit and the load/store port. It gates PC and register-file writes to exactly one cycle per retired instruction, halts on `ebreak`, and traps stalled handshakes with a watchdog.

---
 rtl/npc_seq_ctrl.sv | 113 +++++++++++
 tb/tb_npc_seq_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/npc_seq_ctrl.sv
// Multi-cycle instruction sequencer for the NPC core: steps each instruction through
// fetch/decode/execute/memory/writeback, drives the port handshakes and gates retirement.
module npc_seq_ctrl #(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        ifu_req_valid,
    input  logic        ifu_req_ready,
    input  logic        ifu_rvalid,
    input  logic [31:0] ifu_rdata,
    output logic [31:0] instr_q,
    input  logic        cu_mem_en,
    input  logic        cu_mem_wr,
    input  logic        cu_reg_we,
    input  logic [3:0]  cu_alu_ctrl,
    input  logic        cu_ebreak,
    output logic        mdu_start,
    input  logic        mdu_done,
    output logic        lsu_req_valid,
    input  logic        lsu_req_ready,
    input  logic        lsu_rvalid,
    output logic        pc_we,
    output logic        rf_we,
    output logic [63:0] instret,
    output logic        halt,
    output logic        err,
    output logic        busy
);

    typedef enum logic [3:0] {
        IDLE, FETCH, IWAIT, DECODE, EXEC, MREQ, MWAIT, WB, HALT, ERROR
    } state_t;

    localparam logic [15:0] WDOG_LAST = 16'(TIMEOUT - 1);

    state_t      state;
    state_t      nxt;
    logic [15:0] wdog;
    logic        is_mdu;
    logic        waiting;
    logic        expired;

    // Loads and stores follow the same request/response sequence, so the store flag is not needed here.
    logic unused_cu_mem_wr;
    assign unused_cu_mem_wr = cu_mem_wr;

    always_comb begin
        is_mdu  = (cu_alu_ctrl == 4'd3) || (cu_alu_ctrl == 4'd5);
        waiting = (state == IWAIT) || (state == MWAIT) || ((state == EXEC) && is_mdu);
        expired = (wdog == WDOG_LAST);
        nxt     = state;
        case (state)
            IDLE:    nxt = FETCH;
            FETCH:   if (ifu_req_valid && ifu_req_ready) nxt = IWAIT;
            IWAIT: begin
                if (ifu_rvalid)   nxt = DECODE;
                else if (expired) nxt = ERROR;
            end
            DECODE:  nxt = EXEC;
            EXEC: begin
                if (!is_mdu || mdu_done) nxt = cu_mem_en ? MREQ : WB;
                else if (expired)        nxt = ERROR;
            end
            MREQ:    if (lsu_req_valid && lsu_req_ready) nxt = MWAIT;
            MWAIT: begin
                if (lsu_rvalid)   nxt = WB;
                else if (expired) nxt = ERROR;
            end
            WB:      nxt = cu_ebreak ? HALT : FETCH;
            HALT:    nxt = HALT;
            ERROR:   nxt = ERROR;
            default: nxt = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they align with the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            wdog          <= '0;
            instr_q       <= '0;
            instret       <= '0;
            ifu_req_valid <= 1'b0;
            lsu_req_valid <= 1'b0;
            mdu_start     <= 1'b0;
            pc_we         <= 1'b0;
            rf_we         <= 1'b0;
            halt          <= 1'b0;
            err           <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state <= nxt;
            if (nxt != state)
                wdog <= '0;
            else if (waiting)
                wdog <= wdog + 16'd1;
            if (state == IWAIT && ifu_rvalid)
                instr_q <= ifu_rdata;
            if (state == WB)
                instret <= instret + 64'd1;
            ifu_req_valid <= (nxt == FETCH);
            lsu_req_valid <= (nxt == MREQ);
            mdu_start     <= (state == DECODE) && is_mdu;
            pc_we         <= (nxt == WB);
            rf_we         <= (nxt == WB) && cu_reg_we;
            halt          <= (nxt == HALT);
            err           <= (nxt == ERROR);
            busy          <= !(nxt inside {IDLE, HALT, ERROR});
        end
    end

endmodule

// File: tb/tb_npc_seq_ctrl.sv
// Directed bench for npc_seq_ctrl: ALU stream, backpressure, MUL/DIV, reset, watchdog, ebreak.
module tb_npc_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ifu_req_valid, ifu_req_ready, ifu_rvalid;
    logic [31:0] ifu_rdata, instr_q;
    logic        cu_mem_en, cu_mem_wr, cu_reg_we, cu_ebreak;
    logic [3:0]  cu_alu_ctrl;
    logic        mdu_start, mdu_done;
    logic        lsu_req_valid, lsu_req_ready, lsu_rvalid;
    logic        pc_we, rf_we, halt, err, busy;
    logic [63:0] instret;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    npc_seq_ctrl #(.TIMEOUT(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
        .ifu_rvalid(ifu_rvalid), .ifu_rdata(ifu_rdata), .instr_q(instr_q),
        .cu_mem_en(cu_mem_en), .cu_mem_wr(cu_mem_wr), .cu_reg_we(cu_reg_we),
        .cu_alu_ctrl(cu_alu_ctrl), .cu_ebreak(cu_ebreak),
        .mdu_start(mdu_start), .mdu_done(mdu_done),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_rvalid(lsu_rvalid),
        .pc_we(pc_we), .rf_we(rf_we), .instret(instret),
        .halt(halt), .err(err), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "time limit");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cu(input logic mem_en, input logic mem_wr, input logic reg_we,
                          input logic [3:0] alu, input logic ebrk);
        cu_mem_en = mem_en; cu_mem_wr = mem_wr; cu_reg_we = reg_we;
        cu_alu_ctrl = alu; cu_ebreak = ebrk;
    endtask

    // Reset, check every output is cleared, release, and walk into FETCH.
    task automatic apply_reset();
        ifu_req_ready = 0; ifu_rvalid = 0; mdu_done = 0; lsu_req_ready = 0; lsu_rvalid = 0;
        #1 rst_n = 0;
        #1;
        check("rst_ifu_req_valid", 64'(ifu_req_valid), 64'd0);
        check("rst_lsu_req_valid", 64'(lsu_req_valid), 64'd0);
        check("rst_mdu_start", 64'(mdu_start), 64'd0);
        check("rst_pc_we", 64'(pc_we), 64'd0);
        check("rst_rf_we", 64'(rf_we), 64'd0);
        check("rst_halt", 64'(halt), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_instret", instret, 64'd0);
        check("rst_instr_q", 64'(instr_q), 64'd0);
        @(negedge clk);
        rst_n = 1;
        #1;
        check("idle_no_req", 64'(ifu_req_valid), 64'd0);
        step();
        // Raised after the first edge; the fetch port samples it on the second edge.
        check("fetch_after_release", 64'(ifu_req_valid), 64'd1);
        check("busy_fetch", 64'(busy), 64'd1);
    endtask

    // From FETCH: handshake, return the instruction next cycle, end in DECODE.
    task automatic fetch_instr(input logic [31:0] ins);
        check("fetch_req", 64'(ifu_req_valid), 64'd1);
        ifu_rdata = ins; ifu_req_ready = 1;
        step();
        ifu_req_ready = 0; ifu_rvalid = 1;
        step();
        ifu_rvalid = 0; ifu_rdata = ~ins;
        check("instr_q_latch", 64'(instr_q), 64'(ins));
    endtask

    logic [31:0] addi_tab [3] = '{32'h00150513, 32'h00258593, 32'h00360613};
    logic        hs;

    initial begin
        rst_n = 1; ifu_rdata = 0;
        set_cu(0, 0, 1, 4'd0, 0);
        apply_reset();

        // ALU stream: three addi, rvalid one cycle after each handshake.
        ifu_req_ready = 1; hs = 0;
        for (int c = 1; c <= 15; c++) begin
            ifu_rvalid = hs;
            hs = ifu_req_valid & ifu_req_ready;
            ifu_rdata = addi_tab[(c - 1) / 5];
            check("alu_pc_we", 64'(pc_we), 64'(c % 5 == 0));
            check("alu_rf_we", 64'(rf_we), 64'(c % 5 == 0));
            if (c % 5 == 3) check("alu_instr_q", 64'(instr_q), 64'(addi_tab[(c - 1) / 5]));
            step();
        end
        ifu_req_ready = 0; ifu_rvalid = 0;
        check("alu_instret", instret, 64'd3);

        // Fetch backpressure for 7 cycles, then an sd with LSU backpressure for 4 cycles.
        for (int i = 0; i < 7; i++) begin
            check("ifu_hold", 64'(ifu_req_valid), 64'd1);
            step();
        end
        set_cu(1, 1, 0, 4'd0, 0);
        fetch_instr(32'h00b53023);
        step();
        step();
        for (int i = 0; i < 4; i++) begin
            check("lsu_hold", 64'(lsu_req_valid), 64'd1);
            step();
        end
        check("lsu_hold_end", 64'(lsu_req_valid), 64'd1);
        lsu_req_ready = 1; lsu_rvalid = 1;
        step();
        lsu_req_ready = 0; lsu_rvalid = 0;
        check("lsu_req_drop", 64'(lsu_req_valid), 64'd0);
        step();
        check("mwait_early_rvalid_ignored", 64'(pc_we), 64'd0);
        lsu_rvalid = 1;
        step();
        lsu_rvalid = 0;
        check("sd_pc_we", 64'(pc_we), 64'd1);
        check("sd_rf_we", 64'(rf_we), 64'd0);
        check("sd_instr_q_stable", 64'(instr_q), 64'h00b53023);
        step();
        check("sd_err", 64'(err), 64'd0);
        check("sd_instret", instret, 64'd4);

        // MUL with done 3 cycles after start: EXEC lasts 4 cycles.
        set_cu(0, 0, 1, 4'd5, 0);
        fetch_instr(32'h02b50533);
        step();
        check("mul_start", 64'(mdu_start), 64'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            check("mul_no_restart", 64'(mdu_start), 64'd0);
            check("mul_wait_pc_we", 64'(pc_we), 64'd0);
        end
        mdu_done = 1;
        step();
        mdu_done = 0;
        check("mul_wb_pc_we", 64'(pc_we), 64'd1);
        check("mul_wb_rf_we", 64'(rf_we), 64'd1);
        check("mul_wb_start", 64'(mdu_start), 64'd0);
        step();
        check("mul_instret", instret, 64'd5);

        // ld parked in MWAIT, then reset mid-instruction.
        set_cu(1, 0, 1, 4'd0, 0);
        fetch_instr(32'h00053583);
        step();
        step();
        check("ld_mreq", 64'(lsu_req_valid), 64'd1);
        lsu_req_ready = 1;
        step();
        lsu_req_ready = 0;
        check("ld_mwait_busy", 64'(busy), 64'd1);
        check("ld_pre_reset_instret", instret, 64'd5);
        apply_reset();

        // DIV with done on the start cycle: EXEC lasts 1 cycle.
        set_cu(0, 0, 1, 4'd3, 0);
        fetch_instr(32'h02b54533);
        step();
        check("div_start", 64'(mdu_start), 64'd1);
        mdu_done = 1;
        step();
        mdu_done = 0;
        check("div_wb_pc_we", 64'(pc_we), 64'd1);
        check("div_wb_start", 64'(mdu_start), 64'd0);
        step();
        check("div_instret", instret, 64'd1);

        // Watchdog boundary: response on the 8th MWAIT cycle still wins.
        set_cu(1, 0, 1, 4'd0, 0);
        fetch_instr(32'h00053603);
        step();
        step();
        lsu_req_ready = 1;
        step();
        lsu_req_ready = 0;
        for (int k = 1; k <= 7; k++) begin
            check("wd_edge_err", 64'(err), 64'd0);
            step();
        end
        check("wd_edge_busy", 64'(busy), 64'd1);
        lsu_rvalid = 1;
        step();
        lsu_rvalid = 0;
        check("wd_edge_wb", 64'(pc_we), 64'd1);
        check("wd_edge_no_err", 64'(err), 64'd0);
        step();
        check("wd_edge_instret", instret, 64'd2);

        // ebreak retires with a register write, then the sequencer halts.
        set_cu(0, 0, 1, 4'd0, 1);
        fetch_instr(32'h00100073);
        step();
        step();
        check("ebreak_pc_we", 64'(pc_we), 64'd1);
        check("ebreak_rf_we", 64'(rf_we), 64'd1);
        check("ebreak_halt_pre", 64'(halt), 64'd0);
        step();
        check("halt_set", 64'(halt), 64'd1);
        check("halt_busy", 64'(busy), 64'd0);
        check("halt_pc_we", 64'(pc_we), 64'd0);
        check("halt_err", 64'(err), 64'd0);
        check("halt_instret", instret, 64'd3);
        ifu_req_ready = 1; ifu_rvalid = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("halt_no_fetch", 64'(ifu_req_valid), 64'd0);
        end
        set_cu(1, 0, 1, 4'd0, 0);
        apply_reset();

        // Watchdog expiry: lsu_rvalid never arrives.
        fetch_instr(32'h00053683);
        step();
        step();
        lsu_req_ready = 1;
        step();
        lsu_req_ready = 0;
        for (int k = 1; k <= 8; k++) begin
            check("wd_wait_err", 64'(err), 64'd0);
            check("wd_wait_pc_we", 64'(pc_we), 64'd0);
            step();
        end
        check("wd_err", 64'(err), 64'd1);
        check("wd_busy", 64'(busy), 64'd0);
        check("wd_pc_we", 64'(pc_we), 64'd0);
        check("wd_halt", 64'(halt), 64'd0);
        check("wd_instret", instret, 64'd0);
        ifu_req_ready = 1; lsu_rvalid = 1;
        step();
        check("err_sticky", 64'(err), 64'd1);
        check("err_no_fetch", 64'(ifu_req_valid), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
